// File: rtl/dmem_if.sv
// CPU load/store port between a requesting core (master) and a data-memory responder (slave).
// One request channel with ready/valid, one response channel with valid/ready.
interface dmem_if #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic [STRB_W-1:0]        req_wstrb;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_WIDTH-1:0]    rsp_rdata;
   logic                     rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word loads and byte-strobed stores on an
// internal RAM, completed a fixed number of cycles after acceptance.
module dmem_responder #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH_WORDS   = 256,
   parameter int unsigned LATENCY       = 2,
   parameter int unsigned BASE_ADDR     = 0
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [STRB_W-1:0]        wstrb_q, wstrb_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                     rsp_err_q, rsp_err_d;

   logic [DATA_WIDTH-1:0]    ram_q [DEPTH_WORDS];

   logic [ADDRESS_WIDTH-1:0] off_c;
   logic [IDX_W-1:0]         idx_c;
   logic                     err_c;
   logic [DATA_WIDTH-1:0]    merged_c;
   logic                     ram_wr_c;

   // Decode of the latched address; below-base addresses wrap and are caught explicitly.
   always_comb begin
      off_c = addr_q - ADDRESS_WIDTH'(BASE_ADDR);
      idx_c = off_c[IDX_W+1:2];
      err_c = (addr_q[1:0] != 2'b00)
           || (addr_q < ADDRESS_WIDTH'(BASE_ADDR))
           || ((off_c >> 2) >= ADDRESS_WIDTH'(DEPTH_WORDS));
   end

   // Byte-lane merge of store data over the current word.
   always_comb begin
      merged_c = ram_q[idx_c];
      for (int b = 0; b < int'(STRB_W); b++) begin
         if (wstrb_q[b]) merged_c[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      ram_wr_c    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wstrb_d = bus.req_wstrb;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               ram_wr_c    = !err_c && we_q;
               rsp_rdata_d = (!err_c && !we_q) ? ram_q[idx_c] : '0;
               rsp_err_d   = err_c;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // RAM is not reset; a reset on the commit edge must still block the store.
   always_ff @(posedge clk) begin
      if (ram_wr_c && !rst) ram_q[idx_c] <= merged_c;
   end

   assign bus.req_ready = (state_q == S_IDLE) && !rst;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule
